// File: rtl/c15xx_trk_pkg.sv
// Shared types and zone arithmetic for the IEC drive track loader.
// Sector layout follows the four-zone GCR density map of the 1541/1571.
package c15xx_trk_pkg;

  typedef enum logic [1:0] {IDLE, SAVE, LOAD, INIT} trk_state_e;

  localparam int Z1_END = 17;
  localparam int Z2_END = 24;
  localparam int Z3_END = 30;

  localparam int Z1_SEC = 21;
  localparam int Z2_SEC = 19;
  localparam int Z3_SEC = 18;
  localparam int Z4_SEC = 17;

  // First sector of each zone, folded from the constants above
  localparam int Z2_BASE = Z1_END * Z1_SEC;
  localparam int Z3_BASE = Z2_BASE + (Z2_END - Z1_END) * Z2_SEC;
  localparam int Z4_BASE = Z3_BASE + (Z3_END - Z2_END) * Z3_SEC;

  localparam logic [5:0] TRK_INVALID = 6'h3F;

  function automatic int trk_sectors(input logic [5:0] t);
    int ti;
    ti = int'(t);
    if (ti <= Z1_END)      return Z1_SEC;
    else if (ti <= Z2_END) return Z2_SEC;
    else if (ti <= Z3_END) return Z3_SEC;
    else                   return Z4_SEC;
  endfunction

  function automatic int trk_start(input logic [5:0] t);
    int ti;
    ti = int'(t);
    if (ti <= Z1_END)      return (ti - 1) * Z1_SEC;
    else if (ti <= Z2_END) return Z2_BASE + (ti - Z1_END - 1) * Z2_SEC;
    else if (ti <= Z3_END) return Z3_BASE + (ti - Z2_END - 1) * Z3_SEC;
    else                   return Z4_BASE + (ti - Z3_END - 1) * Z4_SEC;
  endfunction

  // Track 0 reads as 1; anything past the last track sticks to the last track
  function automatic logic [5:0] trk_clamp(input logic [5:0] t, input int n);
    int ti;
    ti = int'(t);
    if (ti == 0)     return 6'd1;
    else if (ti > n) return 6'(n);
    else             return t;
  endfunction

endpackage

// File: rtl/c15xx_track_loader_if.sv
// SD block-request bus between the track loader (master) and the SD block.
interface c15xx_track_loader_if;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, sd_blk_cnt, sd_rd, sd_wr, input sd_ack);
  modport slave  (input sd_lba, sd_blk_cnt, sd_rd, sd_wr, output sd_ack);
endinterface

// File: rtl/c15xx_trk_addr.sv
// Track/side to SD address: first LBA, sector count minus one, range flag.
module c15xx_trk_addr
  import c15xx_trk_pkg::*;
#(
  parameter int NUM_TRACKS   = 35,
  parameter int SIDE_SECTORS = 683
) (
  input  logic [5:0]  trk,
  input  logic        side,
  output logic [5:0]  trk_eff,
  output logic [31:0] lba,
  output logic [5:0]  blk_cnt,
  output logic        rng_err
);

  always_comb begin
    rng_err = int'(trk) > NUM_TRACKS;
    trk_eff = trk_clamp(trk, NUM_TRACKS);
    lba     = 32'(trk_start(trk_eff)) + (side ? 32'(SIDE_SECTORS) : 32'd0);
    blk_cnt = 6'(trk_sectors(trk_eff) - 1);
  end

endmodule

// File: rtl/c15xx_track_loader.sv
// Whole-track loader/saver between the drive core and the SD block interface.
// Optional ack watchdog: define C15XX_TRK_WATCHDOG_EN.
module c15xx_track_loader
  import c15xx_trk_pkg::*;
#(
  parameter int          NUM_TRACKS   = 35,
  parameter int          DOUBLE_SIDED = 0,
  parameter int          SIDE_SECTORS = 683,
  parameter int          INIT_TRACK   = 18,
  parameter logic [23:0] TIMEOUT      = 24'hFFFFFF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  c15xx_track_loader_if.master        sd,
  input  logic [5:0]                  track,
  input  logic                        side,
  input  logic                        dirty,
  input  logic                        save_track,
  input  logic                        change,
  output logic                        busy,
  output logic                        error
);

  localparam logic SIDE_EN = (DOUBLE_SIDED != 0);

  logic [1:0][5:0] trk_sync;
  logic [1:0]      side_sync, chg_sync, save_sync, dirty_sync;
  logic [5:0]      tgt_trk;
  logic            tgt_side, chg_q, save_q;

  // Target lags the control syncs by one cycle so a simultaneous save goes first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trk_sync   <= '0;
      side_sync  <= '0;
      chg_sync   <= '0;
      save_sync  <= '0;
      dirty_sync <= '0;
      tgt_trk    <= '0;
      tgt_side   <= 1'b0;
      chg_q      <= 1'b0;
      save_q     <= 1'b0;
    end else begin
      trk_sync   <= {trk_sync[0], track};
      side_sync  <= {side_sync[0], side};
      chg_sync   <= {chg_sync[0], change};
      save_sync  <= {save_sync[0], save_track};
      dirty_sync <= {dirty_sync[0], dirty};
      tgt_trk    <= trk_sync[1];
      tgt_side   <= side_sync[1] & SIDE_EN;
      chg_q      <= chg_sync[1];
      save_q     <= save_sync[1];
    end
  end

  logic chg_rise, save_evt, dirty_s;
  assign chg_rise = chg_sync[1] & ~chg_q;
  assign save_evt = save_sync[1] ^ save_q;
  assign dirty_s  = dirty_sync[1];

  trk_state_e state;
  logic [5:0] cur_track;
  logic       cur_side, dirty_flg, redirty, upd_pend, save_pend, ack_seen;

  logic [5:0] tgt_eff;
  logic       differ, save_req, cur_valid, done, idle_save;

  always_comb begin
    tgt_eff   = trk_clamp(tgt_trk, NUM_TRACKS);
    differ    = {tgt_eff, tgt_side} != {cur_track, cur_side};
    save_req  = save_pend | save_evt;
    cur_valid = cur_track != TRK_INVALID;
    done      = ack_seen & ~sd.sd_ack;
    idle_save = save_req ? (cur_valid & dirty_flg) : (~upd_pend & differ & dirty_flg);
  end

  // Single address generator: current track for writes, init or target for reads
  logic [5:0]  a_trk, a_trk_eff, a_cnt;
  logic        a_side, a_rng_err;
  logic [31:0] a_lba;

  always_comb begin
    a_trk  = tgt_trk;
    a_side = tgt_side;
    if (state == IDLE) begin
      if (idle_save) begin
        a_trk  = cur_track;
        a_side = cur_side;
      end else if (!save_req && upd_pend) begin
        a_trk  = 6'(INIT_TRACK);
        a_side = 1'b0;
      end
    end
  end

  c15xx_trk_addr #(
    .NUM_TRACKS   (NUM_TRACKS),
    .SIDE_SECTORS (SIDE_SECTORS)
  ) u_addr (
    .trk     (a_trk),
    .side    (a_side),
    .trk_eff (a_trk_eff),
    .lba     (a_lba),
    .blk_cnt (a_cnt),
    .rng_err (a_rng_err)
  );

  logic wd_hit;
`ifdef C15XX_TRK_WATCHDOG_EN
  logic [23:0] wd_cnt;
  assign wd_hit = (state != IDLE) && !done && (wd_cnt == TIMEOUT - 24'd1);
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cur_track     <= TRK_INVALID;
      cur_side      <= 1'b0;
      dirty_flg     <= 1'b0;
      redirty       <= 1'b0;
      upd_pend      <= 1'b1;
      save_pend     <= 1'b0;
      ack_seen      <= 1'b0;
      sd.sd_rd      <= 1'b0;
      sd.sd_wr      <= 1'b0;
      sd.sd_lba     <= '0;
      sd.sd_blk_cnt <= '0;
      busy          <= 1'b0;
      error         <= 1'b0;
`ifdef C15XX_TRK_WATCHDOG_EN
      wd_cnt        <= '0;
`endif
    end else begin
      if (save_evt) save_pend <= 1'b1;
      if (chg_rise) error <= 1'b0;
`ifdef C15XX_TRK_WATCHDOG_EN
      wd_cnt <= wd_cnt + 24'd1;
`endif
      case (state)
        IDLE: begin
          if (dirty_s) dirty_flg <= 1'b1;
          if (save_req || upd_pend || differ) begin
            if (save_req) save_pend <= 1'b0;
            if (idle_save) begin
              state     <= SAVE;
              sd.sd_wr  <= 1'b1;
              redirty   <= 1'b0;
            end else if (!save_req) begin
              state     <= upd_pend ? INIT : LOAD;
              sd.sd_rd  <= 1'b1;
              cur_track <= a_trk_eff;
              cur_side  <= a_side;
              if (upd_pend) upd_pend <= 1'b0;
              if (a_rng_err) error <= 1'b1;
            end
            if (idle_save || !save_req) begin
              sd.sd_lba     <= a_lba;
              sd.sd_blk_cnt <= a_cnt;
              busy          <= 1'b1;
              ack_seen      <= 1'b0;
`ifdef C15XX_TRK_WATCHDOG_EN
              wd_cnt        <= '0;
`endif
            end
          end
        end
        SAVE, LOAD, INIT: begin
          if (sd.sd_ack) begin
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
            ack_seen <= 1'b1;
          end
          if (state == SAVE && dirty_s) redirty <= 1'b1;
          if (wd_hit) begin
            sd.sd_rd  <= 1'b0;
            sd.sd_wr  <= 1'b0;
            error     <= 1'b1;
            cur_track <= TRK_INVALID;
            dirty_flg <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (done) begin
            if (state == SAVE) dirty_flg <= redirty | dirty_s;
            // A re-dirtied buffer goes back through IDLE to be flushed again
            if (!upd_pend && differ && !(state == SAVE && (redirty || dirty_s))) begin
              state         <= LOAD;
              sd.sd_rd      <= 1'b1;
              sd.sd_lba     <= a_lba;
              sd.sd_blk_cnt <= a_cnt;
              cur_track     <= a_trk_eff;
              cur_side      <= a_side;
              ack_seen      <= 1'b0;
              if (a_rng_err) error <= 1'b1;
`ifdef C15XX_TRK_WATCHDOG_EN
              wd_cnt        <= '0;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Media change wins over any dirty update made this cycle
      if (chg_rise) begin
        upd_pend  <= 1'b1;
        dirty_flg <= 1'b0;
        redirty   <= 1'b0;
      end
    end
  end

endmodule
